// File: rtl/music_pkg.sv
// Shared song-entry layout, scheduler states and default sizing for the chord scheduler.
// ROM entry = {wait flag, note, duration}; address = {song, entry index}.
package music_pkg;

  localparam int ENTRY_W        = 13;
  localparam int NOTE_W         = 6;
  localparam int DUR_W          = 6;
  localparam int SONG_W         = 2;
  localparam int ADDR_W         = 7;
  localparam int IDX_W          = ADDR_W - SONG_W;
  localparam int MAX_VOICES_DEF = 3;
  localparam int SONG_LEN_DEF   = 32;

  typedef struct packed {
    logic              wt;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    READ,
    EXEC,
    WAIT_BEATS,
    DONE
  } state_e;

endpackage

// File: rtl/chord_scheduler.sv
// Walks a song in external ROM, issuing notes to the chords block and pacing waits on beat pulses.
// play=0 freezes everything; start always (re)launches the selected song from entry 0.
module chord_scheduler
  import music_pkg::*;
#(
  parameter int MAX_VOICES = MAX_VOICES_DEF,
  parameter int SONG_LEN   = SONG_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play,
  input  logic [SONG_W-1:0]  song_sel,
  input  logic               start,
  input  logic               beat,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [ENTRY_W-1:0] rom_data,
  output logic [NOTE_W-1:0]  note,
  output logic [DUR_W-1:0]   duration,
  output logic               new_note,
  output logic               song_done,
  output logic               busy,
  output logic               voice_overflow
);

  localparam int VC_W = $clog2(MAX_VOICES + 1);

  state_e             state_q, state_d;
  logic [SONG_W-1:0]  song_q, song_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
  logic [VC_W-1:0]    voices_q, voices_d;
  logic               ovf_q, ovf_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic               new_note_q, new_note_d;

  entry_t entry;
  logic   entry_end;
  logic   last_idx;

  assign entry     = rom_data;
  assign entry_end = (rom_data == '0);
  assign last_idx  = (idx_q == IDX_W'(SONG_LEN - 1));
  assign idx_inc   = last_idx ? '0 : idx_q + IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      song_q     <= '0;
      idx_q      <= '0;
      voices_q   <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      note_q     <= '0;
      dur_q      <= '0;
      new_note_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      song_q     <= song_d;
      idx_q      <= idx_d;
      voices_q   <= voices_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      new_note_q <= new_note_d;
    end
  end

  // The index has already advanced past the last entry when waiting, so idx 0 here means the song wrapped.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = FETCH;
    end else if (play) begin
      unique case (state_q)
        IDLE:  state_d = IDLE;
        FETCH: state_d = READ;
        READ:  state_d = EXEC;
        EXEC: begin
          if (entry_end) begin
            state_d = DONE;
          end else if (entry.wt && (entry.dur != '0)) begin
            state_d = WAIT_BEATS;
          end else begin
            state_d = last_idx ? DONE : FETCH;
          end
        end
        WAIT_BEATS: begin
          if (beat && (cnt_q == DUR_W'(1))) begin
            state_d = (idx_q == '0) ? DONE : FETCH;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    song_d     = song_q;
    idx_d      = idx_q;
    voices_d   = voices_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    note_d     = note_q;
    dur_d      = dur_q;
    new_note_d = new_note_q;
    if (start) begin
      song_d     = song_sel;
      idx_d      = '0;
      voices_d   = '0;
      ovf_d      = 1'b0;
      cnt_d      = '0;
      new_note_d = 1'b0;
    end else if (play) begin
      new_note_d = 1'b0;
      if (state_q == EXEC && !entry_end) begin
        idx_d = idx_inc;
        if (entry.wt) begin
          cnt_d    = entry.dur;
          voices_d = '0;
        end else if (entry.note != '0) begin
          if (voices_q < VC_W'(MAX_VOICES)) begin
            note_d     = entry.note;
            dur_d      = entry.dur;
            new_note_d = 1'b1;
            voices_d   = voices_q + VC_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end else if (state_q == WAIT_BEATS && beat) begin
        cnt_d = cnt_q - DUR_W'(1);
      end
    end
  end

  // Pulses are suppressed while paused; a pending new_note is released when play returns.
  assign new_note       = new_note_q & play;
  assign song_done      = (state_q == DONE) & play;
  assign busy           = (state_q != IDLE);
  assign rom_addr       = {song_q, idx_q};
  assign note           = note_q;
  assign duration       = dur_q;
  assign voice_overflow = ovf_q;

endmodule
